ps2_kb_tx: RTL and testbench

- Synthesizable PS/2 device-side (keyboard-end) transmitter.
- Serializes 8-bit scan codes into 11-bit PS/2 frames and drives ps2_clk/ps2_data toward the Y86_shell PS/2 receiver.
- Used as an on-chip keyboard emulator for board bring-up and for self-checking benches in place of hand-toggled stimulus.

---
 rtl/ps2_pkg.sv | 34 +++
 rtl/ps2_phase_tick.sv | 35 +++
 rtl/ps2_kb_tx.sv | 173 +++++++++++++++++
 tb/tb_ps2_kb_tx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 transmitter state encoding, frame constants and parity helpers
// Optional break-prefix build: PS2_KB_TX_BREAK_EN adds the BREAK_PRE state.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

`ifdef PS2_KB_TX_BREAK_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        BIT_HI    = 3'd1,
        BIT_LO    = 3'd2,
        GAP       = 3'd3,
        BREAK_PRE = 3'd4
    } ps2_state_e;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BIT_HI = 2'd1,
        BIT_LO = 2'd2,
        GAP    = 2'd3
    } ps2_state_e;
`endif

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Frame as transmitted LSB first: {stop, parity, d[7:0], start}.
    function automatic logic [PS2_FRAME_BITS-1:0] make_frame(input logic [7:0] d);
        return {1'b1, odd_parity(d), d, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_phase_tick.sv
// rtl/ps2_phase_tick.sv - loadable down-counter with expiry tick for half-phase and gap timing
// tick_o is high while the count sits at zero; loading N-1 gives a tick on the Nth cycle.
module ps2_phase_tick #(
    parameter int CNT_W = 16
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/ps2_kb_tx.sv
// rtl/ps2_kb_tx.sv - PS/2 device-side transmitter serializing scan codes into 11-bit frames
// Define PS2_KB_TX_BREAK_EN to add tx_break, which prefixes the frame with an 0xF0 break frame.
module ps2_kb_tx
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 3200,
    parameter int GAP_CYCLES  = 6400,
    parameter int CNT_W       = 16
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
`ifdef PS2_KB_TX_BREAK_EN
    input  logic       tx_break,
`endif
    output logic       tx_ready,
    output logic       tx_done,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    ps2_state_e                state_q, state_d;
    logic [PS2_FRAME_BITS-1:0] sr_q, sr_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic                      clk_q, clk_d;
    logic                      data_q, data_d;
    logic                      ready_q, ready_d;
    logic                      done_q, done_d;
    logic                      accept;
    logic                      last_frame;
    logic                      load;
    logic [CNT_W-1:0]          load_val;
    logic                      tick;

`ifdef PS2_KB_TX_BREAK_EN
    logic       pend_q, pend_d;
    logic [7:0] hold_q, hold_d;
    assign last_frame = ~pend_q;
`else
    assign last_frame = 1'b1;
`endif

    assign accept = tx_valid && ready_q;

    ps2_phase_tick #(.CNT_W(CNT_W)) u_tick (
        .mclk       (mclk),
        .reset      (reset),
        .load_i     (load),
        .load_val_i (load_val),
        .tick_o     (tick)
    );

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            clk_q     <= 1'b1;
            data_q    <= 1'b1;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
`ifdef PS2_KB_TX_BREAK_EN
            pend_q    <= 1'b0;
            hold_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            clk_q     <= clk_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
`ifdef PS2_KB_TX_BREAK_EN
            pend_q    <= pend_d;
            hold_q    <= hold_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (accept) state_d = BIT_HI;
            BIT_HI: if (tick) state_d = BIT_LO;
            BIT_LO: if (tick) state_d = (bit_cnt_q == LAST_BIT) ? GAP : BIT_HI;
`ifdef PS2_KB_TX_BREAK_EN
            GAP:       if (tick) state_d = pend_q ? BREAK_PRE : IDLE;
            BREAK_PRE: state_d = BIT_HI;
`else
            GAP:    if (tick) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        clk_d     = clk_q;
        data_d    = data_q;
        done_d    = 1'b0;
        load      = 1'b0;
        load_val  = HALF_M1;
        ready_d   = (state_d == IDLE);
`ifdef PS2_KB_TX_BREAK_EN
        pend_d    = pend_q;
        hold_d    = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d      = make_frame(tx_data);
`ifdef PS2_KB_TX_BREAK_EN
                    if (tx_break) begin
                        sr_d   = make_frame(PS2_BREAK_CODE);
                        pend_d = 1'b1;
                        hold_d = tx_data;
                    end
`endif
                    bit_cnt_d = '0;
                    data_d    = 1'b0;
                    clk_d     = 1'b1;
                    load      = 1'b1;
                end
            end
            BIT_HI: begin
                if (tick) begin
                    clk_d = 1'b0;
                    load  = 1'b1;
                end
            end
            BIT_LO: begin
                if (tick) begin
                    clk_d = 1'b1;
                    load  = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        data_d   = 1'b1;
                        load_val = GAP_M1;
                        done_d   = last_frame;
                    end else begin
                        // Rotate rather than shift so every register bit stays live.
                        sr_d      = {sr_q[0], sr_q[PS2_FRAME_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        data_d    = sr_q[1];
                    end
                end
            end
`ifdef PS2_KB_TX_BREAK_EN
            BREAK_PRE: begin
                sr_d      = make_frame(hold_q);
                pend_d    = 1'b0;
                bit_cnt_d = '0;
                data_d    = 1'b0;
                clk_d     = 1'b1;
                load      = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign tx_ready = ready_q;
    assign tx_done  = done_q;
    assign ps2_clk  = clk_q;
    assign ps2_data = data_q;

endmodule

// File: tb/tb_ps2_kb_tx.sv
// tb/tb_ps2_kb_tx.sv - directed self-checking bench for ps2_kb_tx (HALF_PERIOD=4, GAP_CYCLES=8)
// With PS2_KB_TX_BREAK_EN defined, the break-prefix sequence is exercised as well.
module tb_ps2_kb_tx;

    localparam int HP = 4;
    localparam int GP = 8;

    logic       mclk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, ps2_clk, ps2_data;
`ifdef PS2_KB_TX_BREAK_EN
    logic       tx_break = 1'b0;
`endif

    int n_total = 0;
    int n_bad   = 0;

    logic [10:0] frames[$];
    logic [10:0] fr;
    int          nbits = 0;
    int          run = 0;
    int          last_idle = 0;
    int          done_cnt = 0;
    logic        prev_clk = 1'b1;

    always #5 mclk = ~mclk;

    ps2_kb_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GP), .CNT_W(16)) dut (
        .mclk     (mclk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
`ifdef PS2_KB_TX_BREAK_EN
        .tx_break (tx_break),
`endif
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    // Host-side model: sample data on each ps2_clk falling edge, track idle-bus runs.
    always @(negedge mclk) begin
        if (reset) begin
            nbits    = 0;
            run      = 0;
            prev_clk = 1'b1;
        end else begin
            if (prev_clk && !ps2_clk) begin
                fr[nbits] = ps2_data;
                nbits++;
                if (nbits == 11) begin
                    frames.push_back(fr);
                    nbits = 0;
                end
            end
            if (ps2_clk && ps2_data) begin
                run++;
            end else begin
                if (ps2_clk && !ps2_data && run > 0) last_idle = run;
                run = 0;
            end
            if (tx_done) done_cnt++;
            prev_clk = ps2_clk;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [10:0] exp);
        logic [10:0] f;
        f = (frames.size() > 0) ? frames.pop_front() : 11'h7FF;
        chk(tag, 32'(f), 32'(exp));
    endtask

    task automatic start_byte(input logic [7:0] b);
        int i;
        @(negedge mclk);
        for (i = 0; i < 1000 && !tx_ready; i++) @(negedge mclk);
        if (!tx_ready) chk("start_timeout", 32'(tx_ready), 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge mclk);
        @(negedge mclk);
        tx_valid = 1'b0;
    endtask

    // Entered on the negedge after the accept edge; the accept cycle counts as cycle 1.
    task automatic wait_ready(output int cyc);
        cyc = 1;
        while (!tx_ready && cyc < 1000) begin
            @(posedge mclk);
            @(negedge mclk);
            cyc++;
        end
        if (!tx_ready) chk("ready_timeout", 32'(tx_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int d0;
        int i;

        repeat (3) @(negedge mclk);
        chk("rst_clk",   32'(ps2_clk),  32'd1);
        chk("rst_data",  32'(ps2_data), 32'd1);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_done",  32'(tx_done),  32'd0);
        reset = 1'b0;

        // Single frame 0x33: bits 0,1,1,0,0,1,1,0,0,1,1
        start_byte(8'h33);
        wait_ready(lat);
        chk("lat_33", 32'(lat), 32'd97);
        chk("nfr_33", 32'(frames.size()), 32'd1);
        pop_chk("fr_33", 11'h666);
        chk("done_33", 32'(done_cnt), 32'd1);

        // Back-to-back 0x12 then 0x33 with tx_valid held high
        @(negedge mclk);
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        @(posedge mclk);
        @(negedge mclk);
        tx_data  = 8'h33;
        wait_ready(lat);
        chk("lat_b2b_a", 32'(lat), 32'd97);
        @(posedge mclk);
        @(negedge mclk);
        tx_valid = 1'b0;
        wait_ready(lat);
        chk("lat_b2b_b", 32'(lat), 32'd97);
        chk("nfr_b2b", 32'(frames.size()), 32'd2);
        pop_chk("fr_12", 11'h624);
        pop_chk("fr_33b", 11'h666);
        chk("idle_b2b", 32'(last_idle), 32'd9);
        chk("done_b2b", 32'(done_cnt), 32'd3);

        // Parity corner cases
        start_byte(8'h01);
        wait_ready(lat);
        fr = (frames.size() > 0) ? frames[0] : 11'h7FF;
        chk("par_01", 32'(fr[9]), 32'd0);
        pop_chk("fr_01", 11'h402);
        start_byte(8'h00);
        wait_ready(lat);
        fr = (frames.size() > 0) ? frames[0] : 11'h7FF;
        chk("par_00", 32'(fr[9]), 32'd1);
        pop_chk("fr_00", 11'h600);

        // Asynchronous reset during bit 5 of 0x33
        d0 = done_cnt;
        start_byte(8'h33);
        for (i = 0; i < 400 && nbits != 6; i++) @(negedge mclk);
        chk("mid_bit5_seen", 32'(nbits), 32'd6);
        chk("mid_clk_low", 32'(ps2_clk), 32'd0);
        #1 reset = 1'b1;
        #1;
        chk("arst_clk",   32'(ps2_clk),  32'd1);
        chk("arst_data",  32'(ps2_data), 32'd1);
        chk("arst_ready", 32'(tx_ready), 32'd1);
        @(negedge mclk);
        @(negedge mclk);
        reset = 1'b0;
        chk("arst_nfr", 32'(frames.size()), 32'd0);
        start_byte(8'h12);
        wait_ready(lat);
        chk("arst_lat", 32'(lat), 32'd97);
        chk("arst_nfr2", 32'(frames.size()), 32'd1);
        pop_chk("arst_fr_12", 11'h624);
        chk("arst_done", 32'(done_cnt), 32'(d0 + 1));

        // tx_valid with 0xAA mid-frame is ignored
        d0 = done_cnt;
        start_byte(8'h33);
        repeat (30) @(negedge mclk);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge mclk);
        tx_valid = 1'b0;
        wait_ready(lat);
        repeat (3 * GP) @(negedge mclk);
        chk("ign_nfr", 32'(frames.size()), 32'd1);
        pop_chk("ign_fr_33", 11'h666);
        chk("ign_done", 32'(done_cnt), 32'(d0 + 1));
        chk("ign_idle", 32'({ps2_clk, ps2_data, tx_ready}), 32'h7);

`ifdef PS2_KB_TX_BREAK_EN
        // Break prefix: 0xF0 frame, then 0x33, single tx_done
        d0 = done_cnt;
        tx_break = 1'b1;
        start_byte(8'h33);
        tx_break = 1'b0;
        wait_ready(lat);
        chk("brk_lat", 32'(lat), 32'd194);
        chk("brk_nfr", 32'(frames.size()), 32'd2);
        pop_chk("brk_fr_f0", 11'h7E0);
        pop_chk("brk_fr_33", 11'h666);
        chk("brk_done", 32'(done_cnt), 32'(d0 + 1));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
